icache_fill_ctrl: RTL and testbench
===================================

// Module: icache_fill_ctrl
// PURPOSE
//  Sequences cacheline programming of the PA_Core i-cache from a byte stream: one address byte, then LINE_BYTES data bytes.
//  Assembles a 256-bit line and issues a one-cycle write on the i-cache's single port, which is shared with fetch.
//  Arbitrates that port: fetch has priority; a starvation counter guarantees the pending fill eventually wins.
//  Sits between the external programming shift interface (re-timed to clock_i) and the i-cache write side.
// PARAMETERS
//  LINE_BYTES   32   data bytes per cacheline
//  LINE_W       256  cacheline width in bits (LINE_BYTES*8)
//  ADDR_W       8    cacheline index width
//  STARVE_MAX   4    consecutive cycles a pending fill yields to fetch before it forces the port
// PORTS
//  clock_i        in   1       core clock
//  reset_i        in   1       synchronous, active-high reset
//  byteValid_i    in   1       byte stream valid
//  byteData_i     in   8       stream byte
//  byteIsAddr_i   in   1       1: byte is line index; 0: data byte
//  byteReady_o    out  1       controller accepts a byte this cycle
//  fetchReq_i     in   1       fetch requests the i-cache port this cycle
//  fetchGrant_o   out  1       fetch owns the port this cycle
//  cacheWrEn_o    out  1       one-cycle line write strobe
//  cacheWrAddr_o  out  ADDR_W  line index for the write
//  cacheWrData_o  out  LINE_W  assembled line; byte i at [8*i +: 8]
//  busy_o         out  1       a line is partially collected or pending commit
//  protoErr_o     out  1       one-cycle pulse on a stream protocol violation
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE; all registered outputs 0; byte counter 0; starvation counter 0.
//  Reset mid-operation: the partial or pending line is discarded and no write is issued.
//  byteReady_o: 1 in IDLE/COLLECT (and CHECK), 0 in COMMIT, 0 while reset_i is high. A byte transfers when valid&ready.
//  IDLE:
//   - Address byte: latch cacheWrAddr_o, clear the counter, go to COLLECT.
//   - Data byte: dropped; protoErr_o pulses.
//  COLLECT:
//   - Data byte k goes to line[8*k +: 8]; the counter increments.
//   - On byte LINE_BYTES-1, go to COMMIT (or CHECK if the macro is defined).
//   - Address byte: restart with the new index, partial data discarded; protoErr_o pulses.
//  COMMIT:
//   - Fill wins the port if fetchReq_i==0 or starve==STARVE_MAX.
//   - Win: cacheWrEn_o=1 for one cycle, fetchGrant_o=0, starve<=0, state<=IDLE.
//   - Lose: fetchGrant_o=1, starve increments (saturates at STARVE_MAX).
//  fetchGrant_o is combinational: fetchReq_i & ~(state==COMMIT & fill wins).
//  Latency: last data byte accepted in cycle N; cacheWrEn_o in cycle N+1 if fetch is idle.
//  Worst-case latency is N+1+STARVE_MAX.
//  cacheWrAddr_o/cacheWrData_o hold their values after the write, until the next address byte.
//  busy_o = (state != IDLE).
//  Counter width is clog2(LINE_BYTES)+1 bits; it cannot wrap because COLLECT exits on the last byte.
// CONFIGURATION
//  ICACHE_FILL_CHECKSUM_EN defined:
//   - Adds state CHECK after COLLECT, which accepts one extra byte.
//   - If the byte equals the XOR of the LINE_BYTES data bytes, go to COMMIT.
//   - Otherwise drop the line, pulse protoErr_o, go to IDLE.
//   - An address byte in CHECK is treated as a restart error, as in COLLECT.
//  Undefined: no CHECK state and no XOR logic; COLLECT goes directly to COMMIT.
// STRUCTURE
//  Package pa_icache_pkg:
//   - LINE_BYTES, LINE_W, ADDR_W.
//   - Fill state encoding (IDLE, COLLECT, CHECK, COMMIT).
//   - Port-owner enum (PORT_FETCH, PORT_FILL), shared with the i-cache and fetch stage.
//  Sub-module icache_port_arb:
//   - Holds the starvation counter and the grant logic.
//   - Inputs fillPending/fetchReq; outputs fillWin/fetchGrant.
//  Line assembly and the FSM stay in icache_fill_ctrl.
// TESTING
//  1. Addr 0x00, then bytes 0x00..0x1F, fetch idle -> cacheWrEn_o one cycle after the last byte.
//     Expect cacheWrAddr_o=0x00 and cacheWrData_o[7:0]=0x00, [255:248]=0x1F.
//  2. Same line with fetchReq_i held 1 -> fetchGrant_o=1 for 4 COMMIT cycles.
//     Cycle 5: cacheWrEn_o=1, fetchGrant_o=0; then fetchGrant_o=1 again.
//  3. Data byte 0xAA in IDLE -> protoErr_o pulse, no state change.
//     Addr 0x03, 10 bytes, then addr 0x05 -> protoErr_o pulse.
//     Then 32 bytes -> a single write, to 0x05 only.
//  4. reset_i high for one cycle after byte 20 of a line -> busy_o=0, no write.
//     The next full line writes correctly.
//  5. Checksum (macro defined): 32 bytes 0x01, then checksum 0x00 -> write.
//     Checksum 0x01 instead -> no write, protoErr_o pulse.
//  6. byteValid_i held 1 through COMMIT -> byteReady_o=0, no byte consumed until IDLE.

Source files
------------

// File: rtl/pa_icache_pkg.sv
// Shared definitions for the PA_Core i-cache fill path.
//   LINE_BYTES / LINE_W / ADDR_W / STARVE_MAX : default geometry and arbitration limit
//   fill_state_e : fill controller states (CHECK only reachable with ICACHE_FILL_CHECKSUM_EN)
//   port_owner_e : owner of the single i-cache port, shared with the i-cache and fetch stage
package pa_icache_pkg;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned STARVE_MAX = 4;

  typedef enum logic [1:0] {
    FILL_IDLE    = 2'd0,
    FILL_COLLECT = 2'd1,
    FILL_CHECK   = 2'd2,
    FILL_COMMIT  = 2'd3
  } fill_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_FILL  = 1'b1
  } port_owner_e;

endpackage

// File: rtl/icache_fill_ctrl_port_arb.sv
// icache_port_arb: arbitration of the single i-cache port between fetch and a pending fill.
// Fetch has priority; a pending fill that has yielded STARVE_MAX consecutive cycles
// takes the port on the next cycle.
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   fillPending_i    : a complete line is waiting to be written
//   fetchReq_i       : fetch requests the port this cycle
//   fillWin_o        : fill owns the port this cycle (combinational)
//   fetchGrant_o     : fetch owns the port this cycle (combinational)
module icache_port_arb
  import pa_icache_pkg::*;
#(
  parameter int unsigned STARVE_MAX = pa_icache_pkg::STARVE_MAX
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic fillPending_i,
  input  logic fetchReq_i,
  output logic fillWin_o,
  output logic fetchGrant_o
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  port_owner_e   owner;

  always_comb begin
    owner = PORT_FETCH;
    if (fillPending_i && (!fetchReq_i || starve_q == SW'(STARVE_MAX)))
      owner = PORT_FILL;
  end

  assign fillWin_o    = (owner == PORT_FILL);
  assign fetchGrant_o = fetchReq_i & ~fillWin_o;

  // Counts only cycles in which a pending fill actually yielded to fetch.
  always_comb begin
    starve_d = starve_q;
    if (fillWin_o)
      starve_d = '0;
    else if (fillPending_i && fetchReq_i && starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) starve_q <= '0;
    else         starve_q <= starve_d;
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: programs PA_Core i-cache lines from a byte stream
// (one address byte, then LINE_BYTES data bytes) and writes the assembled
// line through the port shared with fetch.
// Optional feature macro: ICACHE_FILL_CHECKSUM_EN adds a CHECK state that
// accepts one XOR checksum byte after the data bytes.
// Ports:
//   clock_i, reset_i    : clock, synchronous active-high reset
//   byteValid_i/byteData_i/byteIsAddr_i, byteReady_o : byte stream handshake
//   fetchReq_i, fetchGrant_o : fetch side of the shared port
//   cacheWrEn_o/cacheWrAddr_o/cacheWrData_o : line write (byte i at [8*i +: 8])
//   busy_o              : line partially collected or pending commit
//   protoErr_o          : one-cycle pulse after a stream protocol violation
module icache_fill_ctrl
  import pa_icache_pkg::*;
#(
  parameter int unsigned LINE_BYTES = pa_icache_pkg::LINE_BYTES,
  parameter int unsigned LINE_W     = pa_icache_pkg::LINE_W,
  parameter int unsigned ADDR_W     = pa_icache_pkg::ADDR_W,
  parameter int unsigned STARVE_MAX = pa_icache_pkg::STARVE_MAX
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              byteValid_i,
  input  logic [7:0]        byteData_i,
  input  logic              byteIsAddr_i,
  output logic              byteReady_o,
  input  logic              fetchReq_i,
  output logic              fetchGrant_o,
  output logic              cacheWrEn_o,
  output logic [ADDR_W-1:0] cacheWrAddr_o,
  output logic [LINE_W-1:0] cacheWrData_o,
  output logic              busy_o,
  output logic              protoErr_o
);

  localparam int unsigned CNT_W = $clog2(LINE_BYTES) + 1;

  fill_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic              protoErr_q, protoErr_d;
  logic              accept;
  logic              lastByte;
  logic              fillPending;
  logic              fillWin;
`ifdef ICACHE_FILL_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign accept      = byteValid_i & byteReady_o;
  assign lastByte    = (cnt_q == CNT_W'(LINE_BYTES - 1));
  // Gated by reset so a line pending at reset is never written.
  assign fillPending = (state_q == FILL_COMMIT) & ~reset_i;

  icache_port_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .fillPending_i (fillPending),
    .fetchReq_i    (fetchReq_i),
    .fillWin_o     (fillWin),
    .fetchGrant_o  (fetchGrant_o)
  );

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= FILL_IDLE;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      protoErr_q <= protoErr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    protoErr_d = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (accept) begin
          if (byteIsAddr_i) state_d = FILL_COLLECT;
          else              protoErr_d = 1'b1;
        end
      end
      FILL_COLLECT: begin
        if (accept) begin
          if (byteIsAddr_i) begin
            state_d    = FILL_COLLECT;
            protoErr_d = 1'b1;
          end else if (lastByte) begin
`ifdef ICACHE_FILL_CHECKSUM_EN
            state_d = FILL_CHECK;
`else
            state_d = FILL_COMMIT;
`endif
          end
        end
      end
`ifdef ICACHE_FILL_CHECKSUM_EN
      FILL_CHECK: begin
        if (accept) begin
          if (byteIsAddr_i) begin
            state_d    = FILL_COLLECT;
            protoErr_d = 1'b1;
          end else if (byteData_i == csum_q) begin
            state_d = FILL_COMMIT;
          end else begin
            state_d    = FILL_IDLE;
            protoErr_d = 1'b1;
          end
        end
      end
`endif
      FILL_COMMIT: begin
        if (fillWin) state_d = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    byteReady_o = ~reset_i & (state_q != FILL_COMMIT);
    busy_o      = (state_q != FILL_IDLE);
    cacheWrEn_o = fillPending & fillWin;
  end

  assign protoErr_o    = protoErr_q;
  assign cacheWrAddr_o = addr_q;
  assign cacheWrData_o = line_q;

  // Line assembly. An address byte in any accepting state restarts the line;
  // data bytes in IDLE are dropped.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
      line_q <= '0;
`ifdef ICACHE_FILL_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else if (accept) begin
      if (byteIsAddr_i) begin
        addr_q <= byteData_i[ADDR_W-1:0];
        cnt_q  <= '0;
`ifdef ICACHE_FILL_CHECKSUM_EN
        csum_q <= '0;
`endif
      end else if (state_q == FILL_COLLECT) begin
        line_q[8*cnt_q +: 8] <= byteData_i;
        cnt_q                <= cnt_q + CNT_W'(1);
`ifdef ICACHE_FILL_CHECKSUM_EN
        csum_q               <= csum_q ^ byteData_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;
  import pa_icache_pkg::*;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         byteValid_i;
  logic [7:0]   byteData_i;
  logic         byteIsAddr_i;
  logic         byteReady_o;
  logic         fetchReq_i;
  logic         fetchGrant_o;
  logic         cacheWrEn_o;
  logic [7:0]   cacheWrAddr_o;
  logic [255:0] cacheWrData_o;
  logic         busy_o;
  logic         protoErr_o;

  int n_checks = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  int perr_cnt = 0;
  logic [7:0]   last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;

  icache_fill_ctrl dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .byteValid_i   (byteValid_i),
    .byteData_i    (byteData_i),
    .byteIsAddr_i  (byteIsAddr_i),
    .byteReady_o   (byteReady_o),
    .fetchReq_i    (fetchReq_i),
    .fetchGrant_o  (fetchGrant_o),
    .cacheWrEn_o   (cacheWrEn_o),
    .cacheWrAddr_o (cacheWrAddr_o),
    .cacheWrData_o (cacheWrData_o),
    .busy_o        (busy_o),
    .protoErr_o    (protoErr_o)
  );

  always #5 clock_i = ~clock_i;

  // Event monitor: write strobes and error pulses seen at each active edge.
  always @(posedge clock_i) begin
    if (cacheWrEn_o) begin
      wr_cnt++;
      last_wr_addr = cacheWrAddr_o;
      last_wr_data = cacheWrData_o;
    end
    if (protoErr_o) perr_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [7:0] seed);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = seed + 8'(i);
    return r;
  endfunction

  function automatic logic [7:0] xsum(input logic [7:0] seed);
    logic [7:0] r = '0;
    for (int i = 0; i < 32; i++) r = r ^ (seed + 8'(i));
    return r;
  endfunction

  // Drives a byte at the falling edge and returns just after the edge that transfers it.
  task automatic send_byte(input logic [7:0] d, input logic a);
    int n = 0;
    @(negedge clock_i);
    byteValid_i  = 1'b1;
    byteData_i   = d;
    byteIsAddr_i = a;
    #1;
    while (!byteReady_o && n < 20) begin
      @(negedge clock_i); #1;
      n++;
    end
    if (n >= 20) check("ready_wait_bounded", 1, 0);
    @(posedge clock_i);
  endtask

  task automatic send_line(input logic [7:0] addr, input logic [7:0] seed);
    send_byte(addr, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(seed + 8'(i), 1'b0);
`ifdef ICACHE_FILL_CHECKSUM_EN
    send_byte(xsum(seed), 1'b0);
`endif
  endtask

  task automatic idle();
    @(negedge clock_i);
    byteValid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock_i);
    reset_i     = 1'b1;
    byteValid_i = 1'b0;
    fetchReq_i  = 1'b0;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  int wr0, pe0;

  initial begin
    reset_i      = 1'b1;
    byteValid_i  = 1'b0;
    byteData_i   = '0;
    byteIsAddr_i = 1'b0;
    fetchReq_i   = 1'b0;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i); #1;
    check("rst_busy",  busy_o, 0);
    check("rst_wren",  cacheWrEn_o, 0);
    check("rst_ready", byteReady_o, 0);
    check("rst_perr",  protoErr_o, 0);
    check("rst_addr",  cacheWrAddr_o, 0);
    check("rst_data",  cacheWrData_o, 0);
    reset_i = 1'b0;
    #1 check("ready_idle", byteReady_o, 1);

    // 1: basic line, fetch idle
    send_line(8'h00, 8'h00);
    idle(); #1;
    check("t1_wren",   cacheWrEn_o, 1);
    check("t1_grant",  fetchGrant_o, 0);
    check("t1_ready",  byteReady_o, 0);
    check("t1_busy",   busy_o, 1);
    check("t1_addr",   cacheWrAddr_o, 8'h00);
    check("t1_b0",     cacheWrData_o[7:0], 8'h00);
    check("t1_b31",    cacheWrData_o[255:248], 8'h1F);
    check("t1_data",   cacheWrData_o, pat(8'h00));
    @(negedge clock_i); #1;
    check("t1_wren_off", cacheWrEn_o, 0);
    check("t1_busy_off", busy_o, 0);
    check("t1_hold",     cacheWrData_o, pat(8'h00));

    // 2: fetch held high -> fill yields 4 cycles then forces the port
    fetchReq_i = 1'b1;
    wr0 = wr_cnt;
    send_line(8'h00, 8'h00);
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_grant_yield", fetchGrant_o, 1);
      check("t2_wren_yield",  cacheWrEn_o, 0);
      @(negedge clock_i);
    end
    #1;
    check("t2_wren_force",  cacheWrEn_o, 1);
    check("t2_grant_force", fetchGrant_o, 0);
    @(negedge clock_i); #1;
    check("t2_grant_back",  fetchGrant_o, 1);
    check("t2_wren_after",  cacheWrEn_o, 0);
    check("t2_wr_count",    wr_cnt - wr0, 1);
    fetchReq_i = 1'b0;

    // 3: protocol errors
    wr0 = wr_cnt; pe0 = perr_cnt;
    send_byte(8'hAA, 1'b0);
    idle(); #1;
    check("t3_perr_idle", protoErr_o, 1);
    check("t3_busy_idle", busy_o, 0);
    @(negedge clock_i); #1;
    check("t3_perr_pulse", protoErr_o, 0);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    send_line(8'h05, 8'h20);
    idle();
    repeat (3) @(negedge clock_i);
    check("t3_wr_count",  wr_cnt - wr0, 1);
    check("t3_perr_count", perr_cnt - pe0, 2);
    check("t3_wr_addr",   last_wr_addr, 8'h05);
    check("t3_wr_data",   last_wr_data, pat(8'h20));

    // 4: reset mid-line discards it
    wr0 = wr_cnt;
    send_byte(8'h09, 1'b1);
    for (int i = 0; i < 21; i++) send_byte(8'h60 + 8'(i), 1'b0);
    @(negedge clock_i);
    byteValid_i = 1'b0;
    reset_i     = 1'b1;
    #1 check("t4_ready_rst", byteReady_o, 0);
    @(negedge clock_i);
    reset_i = 1'b0;
    #1 check("t4_busy", busy_o, 0);
    repeat (3) @(negedge clock_i);
    check("t4_no_write", wr_cnt - wr0, 0);
    send_line(8'h0A, 8'h40);
    idle();
    repeat (2) @(negedge clock_i);
    check("t4_wr_count", wr_cnt - wr0, 1);
    check("t4_wr_addr",  last_wr_addr, 8'h0A);
    check("t4_wr_data",  last_wr_data, pat(8'h40));

`ifdef ICACHE_FILL_CHECKSUM_EN
    // 5: checksum accept / reject
    wr0 = wr_cnt; pe0 = perr_cnt;
    send_byte(8'h30, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(); #1;
    check("t5_wren_ok", cacheWrEn_o, 1);
    repeat (2) @(negedge clock_i);
    check("t5_wr_count_ok", wr_cnt - wr0, 1);
    check("t5_wr_addr_ok",  last_wr_addr, 8'h30);
    send_byte(8'h31, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    idle(); #1;
    check("t5_perr_bad", protoErr_o, 1);
    check("t5_busy_bad", busy_o, 0);
    repeat (3) @(negedge clock_i);
    check("t5_wr_count_bad", wr_cnt - wr0, 1);
    check("t5_perr_count",   perr_cnt - pe0, 1);
`endif

    // 6: valid held through COMMIT -> nothing consumed until IDLE
    wr0 = wr_cnt;
    fetchReq_i = 1'b1;
    send_line(8'h22, 8'h80);
    @(negedge clock_i);
    byteValid_i  = 1'b1;
    byteData_i   = 8'h77;
    byteIsAddr_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t6_ready_commit", byteReady_o, 0);
      check("t6_addr_hold",    cacheWrAddr_o, 8'h22);
      @(negedge clock_i); #1;
    end
    check("t6_wren",       cacheWrEn_o, 1);
    check("t6_ready_wr",   byteReady_o, 0);
    check("t6_wr_addr",    cacheWrAddr_o, 8'h22);
    @(negedge clock_i); #1;
    check("t6_ready_idle", byteReady_o, 1);
    check("t6_addr_idle",  cacheWrAddr_o, 8'h22);
    idle(); #1;
    check("t6_addr_new",   cacheWrAddr_o, 8'h77);
    check("t6_busy_new",   busy_o, 1);
    check("t6_wr_count",   wr_cnt - wr0, 1);
    check("t6_wr_data",    last_wr_data, pat(8'h80));
    do_reset();
    #1 check("t6_busy_rst", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
